// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and sequencing controller for a 5-stage pipeline.
//
// After reset, every stage reset is held for INIT_CYCLES cycles. The block then
// produces per-stage reset/enable strobes for the following cases:
//   - load-use/RAW stalls
//   - branch flushes (3-cycle penalty, no delay slot)
//   - memory wait freezes
// It also produces the operand forwarding selects.
//
// Optional feature macro: FWD_EN
//   defined   : EXE/MEM results are forwarded; only load-use hazards stall.
//               A store whose rt depends on a load in EXE does not stall:
//               fwd_m tells the datapath to take the store data from the WB write.
//   undefined : no forwarding. Every EXE/MEM match stalls. Selects and fwd_m stay 0.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   inst_data_id[31:0]                ID instruction (rs=[25:21], rt=[20:16])
//   rs_used_id, rt_used_id            ID source register usage flags
//   is_store_id                       ID instruction is a store
//   regw_addr_exe/mem[4:0]            destination register in EXE / MEM
//   wb_wen_exe/mem                    write enable in EXE / MEM
//   wb_data_src_exe/mem               1 = load result in EXE / MEM
//   is_branch_mem                     taken jump/branch resolved in MEM
//   mem_req, mem_ack                  MEM access request / completion
//   {if,id,exe,mem,wb}_{rst,en}       per-stage reset and enable
//   exe_fwd_a_ctrl, exe_fwd_b_ctrl    rs/rt forward select (0 NO, 1 ALU_EXE, 2 ALU_MEM, 3 MEM)
//   fwd_m                             store data comes from the WB write two cycles later
//   stall_cnt, flush_cnt[15:0]        saturating stall-cycle and flush counters
//
// state  | meaning
// INIT   | stage resets held while the init counter runs
// RUN    | normal issue; flush / stall / forwarding decided combinationally
// MWAIT  | memory access outstanding, whole pipeline frozen until mem_ack

module pipeline_ctrl #(
  parameter int unsigned INIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_data_id,
  input  logic        rs_used_id,
  input  logic        rt_used_id,
  input  logic        is_store_id,
  input  logic [4:0]  regw_addr_exe,
  input  logic [4:0]  regw_addr_mem,
  input  logic        wb_wen_exe,
  input  logic        wb_wen_mem,
  input  logic        wb_data_src_exe,
  input  logic        wb_data_src_mem,
  input  logic        is_branch_mem,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        if_rst,
  output logic        if_en,
  output logic        id_rst,
  output logic        id_en,
  output logic        exe_rst,
  output logic        exe_en,
  output logic        mem_rst,
  output logic        mem_en,
  output logic        wb_rst,
  output logic        wb_en,
  output logic [1:0]  exe_fwd_a_ctrl,
  output logic [1:0]  exe_fwd_b_ctrl,
  output logic        fwd_m,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0] FWD_NO      = 2'd0;
  localparam logic [1:0] FWD_ALU_EXE = 2'd1;
  localparam logic [1:0] FWD_ALU_MEM = 2'd2;
  localparam logic [1:0] FWD_MEM     = 2'd3;
  localparam logic [3:0] INIT_LAST   = 4'(INIT_CYCLES - 1);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_MWAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  init_cnt_q, init_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic [4:0]  rs_id, rt_id;
  logic        match_exe_rs, match_exe_rt, match_mem_rs, match_mem_rt;
  logic        hazard;
  logic        store_fwd;
  logic [1:0]  fwd_a_raw, fwd_b_raw;
  logic        wait_mem;
  logic        issue;
  logic        flush_now, stall_now;

  assign rs_id = inst_data_id[25:21];
  assign rt_id = inst_data_id[20:16];

  // Register 0 is hard-wired, so it never creates a dependency.
  assign match_exe_rs = rs_used_id && (rs_id != 5'd0) && wb_wen_exe && (regw_addr_exe == rs_id);
  assign match_exe_rt = rt_used_id && (rt_id != 5'd0) && wb_wen_exe && (regw_addr_exe == rt_id);
  assign match_mem_rs = rs_used_id && (rs_id != 5'd0) && wb_wen_mem && (regw_addr_mem == rs_id);
  assign match_mem_rt = rt_used_id && (rt_id != 5'd0) && wb_wen_mem && (regw_addr_mem == rt_id);

  logic unused_inst;
  assign unused_inst = ^{inst_data_id[31:26], inst_data_id[15:0]};

`ifdef FWD_EN
  logic lu_rs, lu_rt;
  assign lu_rs     = match_exe_rs && wb_data_src_exe;
  assign lu_rt     = match_exe_rt && wb_data_src_exe;
  // A store only needs rt as write data, which can be picked up from WB later.
  assign store_fwd = is_store_id && lu_rt && !lu_rs;
  assign hazard    = lu_rs || (lu_rt && !is_store_id);

  always_comb begin
    fwd_a_raw = FWD_NO;
    if (match_exe_rs) begin
      fwd_a_raw = wb_data_src_exe ? FWD_NO : FWD_ALU_EXE;
    end else if (match_mem_rs) begin
      fwd_a_raw = wb_data_src_mem ? FWD_MEM : FWD_ALU_MEM;
    end
  end

  always_comb begin
    fwd_b_raw = FWD_NO;
    if (match_exe_rt) begin
      fwd_b_raw = wb_data_src_exe ? FWD_NO : FWD_ALU_EXE;
    end else if (match_mem_rt) begin
      fwd_b_raw = wb_data_src_mem ? FWD_MEM : FWD_ALU_MEM;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{wb_data_src_exe, wb_data_src_mem, is_store_id};
  assign store_fwd  = 1'b0;
  assign hazard     = match_exe_rs || match_exe_rt || match_mem_rs || match_mem_rt;
  assign fwd_a_raw  = FWD_NO;
  assign fwd_b_raw  = FWD_NO;
`endif

  // The freeze begins in the same cycle as the unacknowledged request. It ends
  // in the cycle that mem_ack arrives, and that cycle follows normal RUN rules.
  assign wait_mem = ((state_q == S_RUN) && mem_req && !mem_ack) ||
                    ((state_q == S_MWAIT) && !mem_ack);
  assign issue     = ((state_q == S_RUN) || (state_q == S_MWAIT)) && !wait_mem;
  assign flush_now = issue && is_branch_mem;
  assign stall_now = issue && !is_branch_mem && hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      init_cnt_q  <= 4'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = S_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 4'd1;
        end
      end
      S_RUN, S_MWAIT: state_d = wait_mem ? S_MWAIT : S_RUN;
      default:        state_d = S_INIT;
    endcase

    stall_cnt_d = (stall_now && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (flush_now && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end

  always_comb begin
    if_rst         = 1'b0;
    if_en          = 1'b0;
    id_rst         = 1'b0;
    id_en          = 1'b0;
    exe_rst        = 1'b0;
    exe_en         = 1'b0;
    mem_rst        = 1'b0;
    mem_en         = 1'b0;
    wb_rst         = 1'b0;
    wb_en          = 1'b0;
    exe_fwd_a_ctrl = FWD_NO;
    exe_fwd_b_ctrl = FWD_NO;
    fwd_m          = 1'b0;
    if (!((state_q == S_RUN) || (state_q == S_MWAIT))) begin
      if_rst  = 1'b1;
      id_rst  = 1'b1;
      exe_rst = 1'b1;
      mem_rst = 1'b1;
      wb_rst  = 1'b1;
    end else if (wait_mem) begin
      // everything frozen: no enables, no resets
    end else if (is_branch_mem) begin
      // IF fetches the target while the three wrong-path stages are squashed.
      if_en   = 1'b1;
      id_rst  = 1'b1;
      id_en   = 1'b1;
      exe_rst = 1'b1;
      exe_en  = 1'b1;
      mem_rst = 1'b1;
      mem_en  = 1'b1;
      wb_en   = 1'b1;
    end else if (hazard) begin
      // IF/ID hold; a bubble goes into EXE while older instructions drain.
      exe_rst = 1'b1;
      exe_en  = 1'b1;
      mem_en  = 1'b1;
      wb_en   = 1'b1;
    end else begin
      if_en          = 1'b1;
      id_en          = 1'b1;
      exe_en         = 1'b1;
      mem_en         = 1'b1;
      wb_en          = 1'b1;
      exe_fwd_a_ctrl = fwd_a_raw;
      exe_fwd_b_ctrl = fwd_b_raw;
      fwd_m          = store_fwd;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: INIT_CYCLES, default 4, number of cycles all stage resets stay asserted after rst deasserts (range 1..15).
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: inst_data_id  in  32  instruction in ID; rs=[25:21], rt=[20:16].
REQ-005 Port: rs_used_id, rt_used_id, is_store_id  in  1 each  decoder flags for the ID instruction.
REQ-006 Port: regw_addr_exe, regw_addr_mem  in  5 each  destination register in EXE, MEM.
REQ-007 Port: wb_wen_exe, wb_wen_mem, wb_data_src_exe, wb_data_src_mem  in  1 each  write enable; data source (1 = load) for EXE, MEM.
REQ-008 Port: is_branch_mem  in  1  jump/branch in MEM; PC loads target on next edge if if_en=1.
REQ-009 Port: mem_req  in  1  MEM stage performs a load/store this cycle; mem_ack  in  1  memory completes access this cycle.
REQ-010 Port: if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en  out  1 each  per-stage reset/enable.
REQ-011 Port: exe_fwd_a_ctrl, exe_fwd_b_ctrl  out  2 each  rs/rt forwarding select: 0 FWD_NO, 1 FWD_ALU_EXE, 2 FWD_ALU_MEM, 3 FWD_MEM.
REQ-012 Port: fwd_m  out  1  store in ID takes its data from the WB write two cycles later.
REQ-013 Port: stall_cnt, flush_cnt  out  16 each  saturating counts of load-use/RAW stall cycles and branch flushes.

Function
REQ-014 FSM states: INIT, RUN, MWAIT; all outputs combinational from state and inputs, except the counters.
REQ-015 INIT: all *_rst=1, all *_en=0, forwarding selects 0, fwd_m=0; after INIT_CYCLES cycles the FSM goes to RUN.
REQ-016 RUN, no hazard: all *_rst=0, all *_en=1.
REQ-017 In RUN, mem_req=1 with mem_ack=0 gives MWAIT in the same cycle: all *_en=0, all *_rst=0, pipeline frozen; the FSM returns to RUN in the cycle mem_ack=1 (that cycle uses RUN rules).
REQ-018 Match(X,s) = source s used, s!=0, wb_wen_X=1, regw_addr_X==s; register 0 never matches.
REQ-019 Forwarding per source, EXE has priority over MEM: EXE match, non-load -> FWD_ALU_EXE; MEM match, non-load -> FWD_ALU_MEM; MEM match, load -> FWD_MEM; otherwise FWD_NO.
REQ-020 Load-use: an EXE match with wb_data_src_exe=1 asserts stall: if_en=0, id_en=0, exe_rst=1, mem/wb enabled, selects FWD_NO; stall_cnt increments.
REQ-021 Exception: is_store_id=1 with the load matching rt only (not rs) gives no stall; fwd_m=1 and exe_fwd_b_ctrl=FWD_NO.
REQ-022 Branch flush: is_branch_mem=1 in RUN gives if_en=1, id_rst=1, exe_rst=1, mem_rst=1, wb enabled; flush_cnt increments; no stall that cycle (penalty 3 cycles, no delay slot).
REQ-023 Priority, highest first: rst, INIT, MWAIT, branch flush, load-use/RAW stall, normal.
REQ-024 Counters saturate at 16'hFFFF; neither increments in INIT or MWAIT.
REQ-025 WB stage is not checked; the register file resolves same-cycle write/read.

Reset
REQ-026 rst=1 at any edge, including mid-MWAIT or mid-stall, gives INIT with the init counter at 0, stall_cnt=0, flush_cnt=0; outputs follow REQ-015 from that edge.

Configuration
REQ-027 Macro FWD_EN: defined, REQ-019/021 apply; undefined, selects are fixed at FWD_NO, fwd_m=0, and any EXE or MEM match (load or not) applies REQ-020 stall.

Verification
REQ-028 rst 1 cycle then 0: *_rst=1 for exactly 4 cycles, then all *_en=1, counters 0.
REQ-029 EXE writes $8 non-load, ID reads rs=$8: exe_fwd_a_ctrl=1; MEM load to $8 instead: exe_fwd_a_ctrl=3; both write $8 with EXE non-load: 1.
REQ-030 EXE load to $9, ID reads rt=$9 (non-store): 1 cycle with if_en=id_en=0, exe_rst=1, stall_cnt 0->1; same case with is_store_id=1: fwd_m=1, no stall.
REQ-031 is_branch_mem=1 together with a load-use hazard: id_rst=exe_rst=mem_rst=1, if_en=1, flush_cnt+1, stall_cnt unchanged.
REQ-032 mem_req=1, mem_ack=0 for 3 cycles then 1: all *_en=0 for 3 cycles, resumes on ack cycle; rst during wait gives INIT.
REQ-033 FWD_EN undefined, EXE non-load writes $8, ID reads $8: stall asserted, selects 0; $0 destination never stalls.
